// File: rtl/image_loader.sv
// ----------------------------------------------------------------------------
// image_loader
// Collects a stream of pixels into one flat frame buffer for the conv layer.
// Pixels arrive on a valid/ready handshake and are stored in arrival order,
// slot 0 being the leftmost slice of the image bus. Once D*H*W pixels are in,
// the buffer is presented as valid and frozen until the consumer acks it.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     in_data carries a pixel
//   in_data      pixel value (DATA_WIDTH bits)
//   in_last      final pixel of a frame
//   in_ready     loader accepts a pixel this cycle (registered)
//   image        flat frame buffer, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   image_valid  image holds a complete frame
//   image_ack    consumer is done with image, buffer may be refilled
//   frame_error  one-cycle pulse on an in_last framing mismatch
//   pixel_count  pixels accepted in the current frame
// ----------------------------------------------------------------------------
module image_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [0:D*H*W*DATA_WIDTH-1]       image,
    output logic                              image_valid,
    input  logic                              image_ack,
    output logic                              frame_error,
    output logic [$clog2(D*H*W):0]            pixel_count
);

    localparam int N  = D * H * W;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(N);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state;
    logic   hs;

    // in_ready is a flop that mirrors state == LOAD, so the handshake never
    // depends combinationally on in_valid.
    assign hs = in_valid && in_ready;

    // ---- control: state, handshake flags, pixel counter ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LOAD;
            in_ready    <= 1'b1;
            image_valid <= 1'b0;
            frame_error <= 1'b0;
            pixel_count <= '0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                LOAD: begin
                    if (hs) begin
                        if (pixel_count == LAST_SLOT) begin
                            // Frame completes on count alone; a missing
                            // in_last is only flagged.
                            state       <= FULL;
                            in_ready    <= 1'b0;
                            image_valid <= 1'b1;
                            pixel_count <= FULL_CNT;
                            frame_error <= !in_last;
                        end else if (in_last) begin
                            // Early in_last: drop the partial frame.
                            pixel_count <= '0;
                            frame_error <= 1'b1;
                        end else begin
                            pixel_count <= pixel_count + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (image_ack) begin
                        state       <= LOAD;
                        in_ready    <= 1'b1;
                        image_valid <= 1'b0;
                        pixel_count <= '0;
                    end
                end
                default: begin
                    state       <= LOAD;
                    in_ready    <= 1'b1;
                    image_valid <= 1'b0;
                end
            endcase
        end
    end

    // ---- data: write the accepted pixel into its slot ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            image <= '0;
        end else if (hs) begin
            for (int i = 0; i < N; i++) begin
                if (pixel_count == CW'(i)) begin
                    image[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// ----------------------------------------------------------------------------
// tb_image_loader
// Directed bench for image_loader with D=1, H=W=4, DATA_WIDTH=16.
// ----------------------------------------------------------------------------
module tb_image_loader;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int IW = N * DW;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_last;
    logic              in_ready;
    logic [0:IW-1]     image;
    logic              image_valid;
    logic              image_ack;
    logic              frame_error;
    logic [4:0]        pixel_count;

    int   checks;
    int   errors;
    logic fe_seen;
    logic [0:IW-1] exp_img;
    logic [0:IW-1] seq_img;

    image_loader #(
        .DATA_WIDTH(DW),
        .D(1),
        .H(4),
        .W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .image(image),
        .image_valid(image_valid),
        .image_ack(image_ack),
        .frame_error(frame_error),
        .pixel_count(pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:IW-1] fill(input logic [DW-1:0] v);
        logic [0:IW-1] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    // One handshake; in_ready is 1 whenever this is called.
    task automatic send(input logic [DW-1:0] v, input logic last);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        fe_seen  = fe_seen | frame_error;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fe_seen = fe_seen | frame_error;
        end
    endtask

    task automatic ack();
        image_ack = 1'b1;
        @(posedge clk);
        #1;
        image_ack = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        fe_seen   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        image_ack = 1'b0;
        reset     = 1'b1;
        for (int k = 0; k < N; k++) seq_img[k*DW +: DW] = DW'(k + 1);

        // Reset state, sampled before any clock edge
        #1 reset = 1'b0;
        #2;
        chk("rst_in_ready",    IW'(in_ready),    IW'(1));
        chk("rst_image_valid", IW'(image_valid), IW'(0));
        chk("rst_frame_error", IW'(frame_error), IW'(0));
        chk("rst_pixel_count", IW'(pixel_count), IW'(0));
        chk("rst_image",       image,            IW'(0));
        @(posedge clk);
        #1 reset = 1'b1;

        // Pixels 1..16, in_last on the 16th
        fe_seen = 1'b0;
        for (int k = 0; k < N; k++) send(DW'(k + 1), k == N - 1);
        chk("t1_image_valid", IW'(image_valid), IW'(1));
        chk("t1_in_ready",    IW'(in_ready),    IW'(0));
        chk("t1_pixel_count", IW'(pixel_count), IW'(16));
        chk("t1_image",       image,            seq_img);
        chk("t1_no_ferr",     IW'(fe_seen),     IW'(0));

        // FULL ignores in_valid, then ack releases
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        idle(5);
        in_valid = 1'b0;
        chk("t2_image_hold",  image,            seq_img);
        chk("t2_count_hold",  IW'(pixel_count), IW'(16));
        chk("t2_valid_hold",  IW'(image_valid), IW'(1));
        ack();
        chk("t2_ack_ready",   IW'(in_ready),    IW'(1));
        chk("t2_ack_valid",   IW'(image_valid), IW'(0));
        chk("t2_ack_count",   IW'(pixel_count), IW'(0));

        // Early in_last on the 5th pixel
        for (int k = 0; k < 4; k++) send(16'h1111, 1'b0);
        chk("t3_count_4",     IW'(pixel_count), IW'(4));
        send(16'hAAAA, 1'b1);
        chk("t3_ferr_pulse",  IW'(frame_error), IW'(1));
        chk("t3_count_clr",   IW'(pixel_count), IW'(0));
        chk("t3_still_load",  IW'(in_ready),    IW'(1));
        idle(1);
        chk("t3_ferr_1cyc",   IW'(frame_error), IW'(0));
        fe_seen = 1'b0;
        for (int k = 0; k < N; k++) send(16'h0003, k == N - 1);
        chk("t3_image",       image,            fill(16'h0003));
        chk("t3_valid",       IW'(image_valid), IW'(1));
        chk("t3_no_ferr",     IW'(fe_seen),     IW'(0));
        ack();

        // No in_last at all: completes, error pulses with image_valid
        for (int k = 0; k < N; k++) begin
            send(DW'(16'h0100 + k), 1'b0);
            if (k == N - 2) chk("t4_no_early_ferr", IW'(frame_error), IW'(0));
        end
        for (int k = 0; k < N; k++) exp_img[k*DW +: DW] = DW'(16'h0100 + k);
        chk("t4_valid",       IW'(image_valid), IW'(1));
        chk("t4_ferr",        IW'(frame_error), IW'(1));
        chk("t4_image",       image,            exp_img);
        idle(1);
        chk("t4_ferr_1cyc",   IW'(frame_error), IW'(0));
        ack();

        // Asynchronous reset mid-frame
        for (int k = 0; k < 7; k++) send(16'h0007, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_count", IW'(pixel_count), IW'(0));
        chk("t5_async_image", image,            IW'(0));
        chk("t5_async_ready", IW'(in_ready),    IW'(1));
        chk("t5_async_valid", IW'(image_valid), IW'(0));
        @(posedge clk);
        #1;
        chk("t5_hold_valid",  IW'(image_valid), IW'(0));
        reset = 1'b1;
        fe_seen = 1'b0;
        for (int k = 0; k < N; k++) send(16'h0005, k == N - 1);
        chk("t5_image",       image,            fill(16'h0005));
        chk("t5_valid",       IW'(image_valid), IW'(1));
        chk("t5_no_ferr",     IW'(fe_seen),     IW'(0));
        ack();

        // Random in_valid gaps, same pixels as the first frame
        fe_seen = 1'b0;
        for (int k = 0; k < N; k++) begin
            while ($urandom_range(1, 0) == 0) idle(1);
            send(DW'(k + 1), k == N - 1);
        end
        chk("t6_image",       image,            seq_img);
        chk("t6_count",       IW'(pixel_count), IW'(16));
        chk("t6_valid",       IW'(image_valid), IW'(1));
        chk("t6_no_ferr",     IW'(fe_seen),     IW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width in bits of one pixel.
REQ-002 The block SHALL have parameter D, default 1, meaning the image depth (channels).
REQ-003 The block SHALL have parameter H, default 32, meaning the image height.
REQ-004 The block SHALL have parameter W, default 32, meaning the image width.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-007 Port in_valid, input, 1 bit: the in_data pixel is valid.
REQ-008 Port in_data, input, DATA_WIDTH bits: the pixel value.
REQ-009 Port in_last, input, 1 bit: marks the final pixel of a frame.
REQ-010 Port in_ready, output, 1 bit: the loader accepts a pixel this cycle.
REQ-011 Port image, output, [0:D*H*W*DATA_WIDTH-1]: the assembled flat image bus feeding the conv layer.
REQ-012 Port image_valid, output, 1 bit: image holds a complete frame.
REQ-013 Port image_ack, input, 1 bit: the consumer has finished with image, and the buffer is released.
REQ-014 Port frame_error, output, 1 bit: one-cycle pulse flagging an in_last framing mismatch.
REQ-015 Port pixel_count, output, clog2(D*H*W)+1 bits: the number of pixels accepted in the current frame.

Function
REQ-016 A handshake SHALL occur on a clock edge when in_valid=1 and in_ready=1; no other cycle SHALL modify image or pixel_count.
REQ-017 Storage order: accepted pixel k (k = d*H*W + r*W + c, zero-based) SHALL be written to image[k*DATA_WIDTH +: DATA_WIDTH]; index 0 is the leftmost (MSB) slice.
REQ-018 The FSM SHALL have exactly two states: LOAD (in_ready=1, image_valid=0) and FULL (in_ready=0, image_valid=1).
REQ-019 In LOAD, each handshake SHALL store the pixel at slot pixel_count and increment pixel_count by 1.
REQ-020 A handshake at pixel_count = D*H*W-1 SHALL complete the frame: next cycle state=FULL, image_valid=1, pixel_count=D*H*W. Latency is 1 cycle from the final handshake to image_valid.
REQ-021 If the completing pixel has in_last=0, the frame SHALL still complete and frame_error SHALL pulse for 1 cycle.
REQ-022 If in_last=1 on a handshake with pixel_count < D*H*W-1, the partial frame SHALL be discarded: pixel_count returns to 0, state stays LOAD, frame_error pulses for 1 cycle, and image slots already written are left unchanged.
REQ-023 In FULL, image and pixel_count SHALL hold constant; in_valid SHALL be ignored.
REQ-024 In FULL, image_ack=1 SHALL move the FSM to LOAD on the next cycle with pixel_count=0; in_ready rises in that cycle.
REQ-025 image_ack in LOAD SHALL be ignored.
REQ-026 The FSM SHALL never be in LOAD and FULL simultaneously.
REQ-027 frame_error SHALL be 0 in every cycle not named in REQ-021/REQ-022.
REQ-028 Outputs SHALL be registered; in_ready SHALL NOT depend combinationally on in_valid.

Reset
REQ-029 While reset=0, and asynchronously on its assertion, the block SHALL set: state=LOAD, in_ready=1, image_valid=0, frame_error=0, pixel_count=0, image=all zeros.
REQ-030 Reset asserted mid-frame or in FULL SHALL discard all progress; the first handshake after reset release SHALL write slot 0.

Verification
REQ-031 D=1, H=W=4: stream 16 pixels with values 1..16, in_last on the 16th -> image_valid=1 one cycle later, slot k = k+1, in_ready=0, frame_error stays 0.
REQ-032 After REQ-031, hold in_valid=1 for 5 cycles with image_ack=0 -> image unchanged, pixel_count=16. Pulse image_ack -> next cycle in_ready=1, image_valid=0, pixel_count=0.
REQ-033 Assert in_last on the 5th pixel (value 0xAAAA) -> frame_error pulses 1 cycle, pixel_count=0. Then send 16 pixels of 0x0003 -> image all 0x0003, image_valid=1.
REQ-034 Send 16 pixels with in_last=0 throughout -> frame completes, image_valid=1, and frame_error pulses in the same cycle image_valid rises.
REQ-035 Drive reset=0 asynchronously after 7 pixels, then release and send 16 pixels of 0x0005 -> every slot reads 0x0005; image_valid was 0 during reset.
REQ-036 Random in_valid gaps (about 50% duty) with pixels 1..16 -> same image as REQ-031, and no pixel is lost or duplicated.
